ahb_mux_nm1s: RTL
=================

# ahb_mux_nm1s

Parametrised AHB-Lite master multiplexer that shares one slave-side AHB-Lite port among NM masters, such as the EL2 IFU, LSU, debug/SB and DMA-style requesters. It is the successor to the two-master IFU/LSU multiplexer: any master count, any data width, and a selectable fixed-priority or round-robin arbiter. It tracks address and data phases separately, routes HWDATA, HRDATA and HRESP to the data-phase owner, and honours HMASTLOCK. It sits between the core/bus masters and the SoC AHB-Lite fabric.

## Interface
Parameters:
- NM, 2: number of masters, legal range 2..8.
- AW, 32: address width.
- DW, 64: data width, 32 or 64.
- ARB_MODE, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round robin.

Ports. Per-master buses are packed, master i at slice [i*W +: W].
- HCLK  in  1  system clock.
- HRESET  in  1  reset, asynchronous, active-high.
- HADDR_M  in  NM*AW  master addresses.
- HTRANS_M  in  NM*2  master transfer types.
- HWRITE_M  in  NM  master write controls.
- HSIZE_M  in  NM*3  master transfer sizes.
- HMASTLOCK_M  in  NM  master lock requests.
- HWDATA_M  in  NM*DW  master write data.
- HREADY_M  out  NM  per-master ready.
- HRDATA_M  out  DW  read data, shared by all masters (HRDATA passed through).
- HRESP_M  out  NM  per-master response.
- HADDR  out  AW  slave-side address.
- HTRANS  out  2  slave-side transfer type.
- HWRITE  out  1  slave-side write control.
- HSIZE  out  3  slave-side size.
- HMASTLOCK  out  1  slave-side lock.
- HWDATA  out  DW  slave-side write data.
- HRDATA  in  DW  slave read data.
- HREADY  in  1  slave ready.
- HRESP  in  1  slave response.

## Operation
State registers:
- aown_vld, aown: address-phase owner and its valid flag.
- dph_vld, dph_own: data-phase owner and its valid flag.
- rr_ptr: round-robin pointer, clog2(NM) bits.

Request and arbitration:
- req[i] = HTRANS_M[i][1], i.e. NONSEQ or SEQ.
- Arbitration is evaluated only at a rising edge where HREADY=1. When HREADY=0, aown and aown_vld hold.
- Keep: if aown_vld and the owner has (HTRANS_M[1] | HTRANS_M==BUSY | HMASTLOCK_M), the owner keeps the bus.
- Otherwise, if any req[i] is set, the winner is chosen as follows:
  - ARB_MODE 0: lowest index.
  - ARB_MODE 1: first requester at or after rr_ptr, cyclic. On that grant rr_ptr <= (winner+1) mod NM.
- On a win: aown <= winner, aown_vld <= 1.
- If no master requests: aown_vld <= 0 and the bus is left unowned.

Slave-side address controls:
- When aown_vld=1, HADDR, HTRANS, HWRITE, HSIZE and HMASTLOCK are taken from master aown.
- When aown_vld=0, all of them are 0 (HTRANS=IDLE).

Data phase:
- At an edge with HREADY=1: dph_vld <= HTRANS[1] and dph_own <= aown.
- At an edge with HREADY=0: dph_vld and dph_own hold.
- HWDATA = HWDATA_M[dph_own] when dph_vld=1, else 0.
- HRESP_M[i] = HRESP if dph_vld and dph_own==i, else 0. The two-cycle ERROR response therefore reaches only the data-phase owner.

HREADY_M[i]:
- HREADY if (dph_vld & dph_own==i) or (aown_vld & aown==i).
- Else 0 if req[i]. A non-owner is stalled and must hold its address.
- Else 1.

Release and conflicts:
- A master loses ownership only after its IDLE is accepted. Its final data phase has therefore completed, and a non-owner never holds a live data phase.
- HMASTLOCK_M on the owner blocks hand-over even through IDLE cycles.

## Timing
Reset (HRESET=1, asynchronous):
- aown_vld=0, dph_vld=0, rr_ptr=0.
- HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HMASTLOCK=0, HWDATA=0, HRESP_M=0.
- HREADY_M = all 1s for idle masters, all 0s for requesting masters.

Latency and hand-over:
- Grant latency on an idle bus: master k raises NONSEQ in cycle t with HREADY=1. HREADY_M[k]=0 in t. k's address appears on HADDR in t+1, with HREADY_M[k]=HREADY.
- Hand-over: owner A drives IDLE in cycle t while HREADY=1 and B is requesting. B's address is driven in t+1. There is no dead cycle beyond the IDLE itself.
- Slave wait states stall the current address owner and the data owner together, and freeze arbitration.

Reset mid-transfer: all state clears immediately. Outstanding transfers are abandoned and the masters are reset with the fabric.

## Test plan
- Reset/idle, NM=4: all HTRANS_M=IDLE -> HTRANS=0 and HREADY_M=4'b1111. Assert HRESET mid-burst -> HTRANS=0 in the same cycle.
- Fixed priority, NM=4, ARB_MODE=0: M1 and M3 both issue NONSEQ in the same cycle -> M1 address (e.g. 0x1000) on HADDR next cycle and HREADY_M[3]=0. M3 (0x3000) is granted one cycle after M1 drives IDLE.
- Round robin, NM=3, ARB_MODE=1: all masters issue single NONSEQs continuously, each followed by IDLE -> grant order 0,1,2,0.
- Wait states, M0 write 0xDEADBEEF_CAFEF00D: slave holds HREADY=0 for 2 cycles -> HWDATA stable for those 2 cycles, M1 stalled, no grant change.
- Error: slave returns HRESP=1 for two cycles on M2's read -> HRESP_M=3'b100 for both cycles, and HREADY_M[2] follows HREADY (0 then 1).
- Lock: M0 asserts HMASTLOCK_M with IDLE gaps between transfers while M1 requests -> M1 is not granted until M0 drops HMASTLOCK_M.

Source files
------------

// File: rtl/ahb_mux_nm1s.sv
// AHB-Lite N-master to 1-slave multiplexer with separate address/data phase tracking.
// Arbitration is fixed priority (ARB_MODE=0) or round robin (ARB_MODE=1).
module ahb_mux_nm1s #(
    parameter int NM       = 2,
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int ARB_MODE = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NM*AW-1:0]   HADDR_M,
    input  logic [NM*2-1:0]    HTRANS_M,
    input  logic [NM-1:0]      HWRITE_M,
    input  logic [NM*3-1:0]    HSIZE_M,
    input  logic [NM-1:0]      HMASTLOCK_M,
    input  logic [NM*DW-1:0]   HWDATA_M,
    output logic [NM-1:0]      HREADY_M,
    output logic [DW-1:0]      HRDATA_M,
    output logic [NM-1:0]      HRESP_M,
    output logic [AW-1:0]      HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic               HMASTLOCK,
    output logic [DW-1:0]      HWDATA,
    input  logic [DW-1:0]      HRDATA,
    input  logic               HREADY,
    input  logic               HRESP
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0] req;
    logic [NM-1:0] busy;
    logic [NM-1:0] lock;
    logic [AW-1:0] haddr_arr  [NM];
    logic [1:0]    htrans_arr [NM];
    logic [2:0]    hsize_arr  [NM];
    logic [DW-1:0] hwdata_arr [NM];

    logic          aown_vld_reg;
    logic [IW-1:0] aown_reg;
    logic          dph_vld_reg;
    logic [IW-1:0] dph_own_reg;
    logic [IW-1:0] rr_ptr_reg;

    logic          any_req;
    logic          owner_keep;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_master
            assign htrans_arr[gi] = HTRANS_M[gi*2 +: 2];
            assign haddr_arr[gi]  = HADDR_M[gi*AW +: AW];
            assign hsize_arr[gi]  = HSIZE_M[gi*3 +: 3];
            assign hwdata_arr[gi] = HWDATA_M[gi*DW +: DW];
            assign req[gi]        = HTRANS_M[gi*2+1];
            assign busy[gi]       = (HTRANS_M[gi*2 +: 2] == 2'b01);
            assign lock[gi]       = HMASTLOCK_M[gi];

            // Only the data-phase owner ever sees a slave response.
            assign HRESP_M[gi] = HRESP & dph_vld_reg & (dph_own_reg == IW'(gi));

            // Owners follow the slave; requesting non-owners are stalled.
            assign HREADY_M[gi] = ((dph_vld_reg  && dph_own_reg == IW'(gi)) ||
                                   (aown_vld_reg && aown_reg    == IW'(gi))) ? HREADY : ~req[gi];
        end
    endgenerate

    assign HRDATA_M   = HRDATA;
    assign any_req    = |req;
    assign owner_keep = aown_vld_reg & (req[aown_reg] | busy[aown_reg] | lock[aown_reg]);

    // Winner select: round robin takes the lowest requester at or above the
    // pointer, wrapping to the lowest requester overall when none is above it.
    always_comb begin
        logic          hi_found;
        logic [IW-1:0] win_lo;
        logic [IW-1:0] win_hi;
        hi_found = 1'b0;
        win_lo   = '0;
        win_hi   = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo = IW'(i);
                if (i >= int'(rr_ptr_reg)) begin
                    win_hi   = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (ARB_MODE == 1) begin
            winner = hi_found ? win_hi : win_lo;
        end else begin
            winner = win_lo;
        end
        rr_next = (winner == IW'(NM - 1)) ? '0 : winner + IW'(1);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aown_vld_reg <= 1'b0;
            aown_reg     <= '0;
            dph_vld_reg  <= 1'b0;
            dph_own_reg  <= '0;
            rr_ptr_reg   <= '0;
        end else if (HREADY) begin
            dph_vld_reg <= HTRANS[1];
            dph_own_reg <= aown_reg;
            if (!owner_keep) begin
                if (any_req) begin
                    aown_reg     <= winner;
                    aown_vld_reg <= 1'b1;
                    if (ARB_MODE == 1) begin
                        rr_ptr_reg <= rr_next;
                    end
                end else begin
                    aown_vld_reg <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        HADDR     = '0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'b000;
        HMASTLOCK = 1'b0;
        if (aown_vld_reg) begin
            HADDR     = haddr_arr[aown_reg];
            HTRANS    = htrans_arr[aown_reg];
            HWRITE    = HWRITE_M[aown_reg];
            HSIZE     = hsize_arr[aown_reg];
            HMASTLOCK = lock[aown_reg];
        end
    end

    always_comb begin
        HWDATA = '0;
        if (dph_vld_reg) begin
            HWDATA = hwdata_arr[dph_own_reg];
        end
    end

endmodule
